time_keeper: RTL

- Time-of-day core fed by the divided slow clock from the clock divider. Runs entirely in the 100 MHz `clk` domain and treats the divider output as a sampled level; every rising edge of that level is one tick.
- Counts ticks into seconds, minutes and hours (24 h, binary) and accepts a time-load request.
- Holds an alarm time and runs an alarm state machine whose ring output drives the buzzer/LED stage.

---
 rtl/time_keeper.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// Time-of-day core: counts slow_clk rising edges into 24 h binary time and
// runs an alarm sequencer whose ring output drives the buzzer/LED stage.
//
// state     | meaning
// S_IDLE    | armed or disarmed, waiting for the time to reach the alarm
// S_RINGING | alarm sounding, ring counter counts elapsed seconds
// S_DONE    | ring finished or stopped, held until the alarm minute passes
module time_keeper #(
    parameter int TICKS_PER_SEC = 200,
    parameter int RING_SECS     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       slow_clk,
    input  logic       run,
    input  logic       load_req,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_min,
    output logic       load_err,
    input  logic       alarm_wr,
    input  logic [4:0] alarm_hour_in,
    input  logic [5:0] alarm_min_in,
    input  logic       alarm_en,
    input  logic       alarm_stop,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sec_pulse,
    output logic       alarm_ring
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RINGING, S_DONE} state_t;

    state_t          state, state_nxt;
    logic            slow_d;
    logic [PW-1:0]   presc;
    logic [4:0]      alarm_hour;
    logic [5:0]      alarm_min;
    logic [7:0]      ring_cnt;
    logic            ring_clr, ring_inc;
    logic            tick, load_ok, load_bad, alarm_bad, sec_adv, alarm_hit, ring_last;
    logic [4:0]      hour_nxt;
    logic [5:0]      min_nxt, sec_nxt;

    assign tick      = slow_clk & ~slow_d;
    assign load_ok   = load_req && (load_hour <= 5'd23) && (load_min <= 6'd59);
    assign load_bad  = load_req && !load_ok;
    assign alarm_bad = alarm_wr && ((alarm_hour_in > 5'd23) || (alarm_min_in > 6'd59));
    // a load in the same cycle swallows the tick
    assign sec_adv   = run && tick && !load_ok && (presc == PRESC_LAST);
    assign alarm_hit = sec_adv && alarm_en && (hour_nxt == alarm_hour) &&
                       (min_nxt == alarm_min) && (sec_nxt == 6'd0);
    assign ring_last = (int'(ring_cnt) + 1) >= RING_SECS;

    always_comb begin
        sec_nxt  = sec + 6'd1;
        min_nxt  = min;
        hour_nxt = hour;
        if (sec == 6'd59) begin
            sec_nxt = 6'd0;
            min_nxt = min + 6'd1;
            if (min == 6'd59) begin
                min_nxt  = 6'd0;
                hour_nxt = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slow_d    <= 1'b1;
            presc     <= '0;
            hour      <= '0;
            min       <= '0;
            sec       <= '0;
            sec_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            slow_d    <= slow_clk;
            sec_pulse <= sec_adv;
            load_err  <= load_bad || alarm_bad;
            if (load_ok) begin
                hour  <= load_hour;
                min   <= load_min;
                sec   <= 6'd0;
                presc <= '0;
            end else if (run && tick) begin
                if (presc == PRESC_LAST) begin
                    presc <= '0;
                    hour  <= hour_nxt;
                    min   <= min_nxt;
                    sec   <= sec_nxt;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_hour <= '0;
            alarm_min  <= '0;
        end else if (alarm_wr && !alarm_bad) begin
            alarm_hour <= alarm_hour_in;
            alarm_min  <= alarm_min_in;
        end
    end

    always_comb begin
        state_nxt = state;
        ring_clr  = 1'b0;
        ring_inc  = 1'b0;
        case (state)
            S_IDLE: begin
                if (alarm_hit) begin
                    state_nxt = S_RINGING;
                    ring_clr  = 1'b1;
                end
            end
            S_RINGING: begin
                if (!alarm_en) begin
                    state_nxt = S_IDLE;
                end else if (alarm_stop) begin
                    state_nxt = S_DONE;
                end else if (sec_adv) begin
                    ring_inc = 1'b1;
                    if (ring_last) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // leaving only once the minute changes blocks a second ring
                if ((min != alarm_min) || !alarm_en) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ring_cnt   <= '0;
            alarm_ring <= 1'b0;
        end else begin
            state      <= state_nxt;
            alarm_ring <= (state_nxt == S_RINGING);
            if (ring_clr) ring_cnt <= '0;
            else if (ring_inc) ring_cnt <= ring_cnt + 8'd1;
        end
    end

endmodule
